// File: rtl/stopwatch_60s_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_60s_pkg
//   Shared definitions for the 0-59 s count-up stopwatch.
//   - NUM_1S_DEFAULT : clock cycles per second on the 12 MHz board clock
//   - LED_ON/LED_OFF : active-low LED bank patterns (all on / all off)
//   - sw_state_t     : stopwatch state encoding
//   - UNITS_MAX/TENS_MAX : BCD digit limits (59 s is the top count)
//   - bcd_t / led_t  : bus types shared by the interface and the RTL
// -----------------------------------------------------------------------------
package stopwatch_60s_pkg;

  localparam logic [23:0] NUM_1S_DEFAULT = 24'd12_000_000;

  localparam logic [13:0] LED_ON  = 14'b0;
  localparam logic [13:0] LED_OFF = 14'b11_1111_1111_1111;

  localparam logic [3:0] UNITS_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;

  typedef logic [7:0]  bcd_t;
  typedef logic [13:0] led_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2,
    FULL = 2'd3
  } sw_state_t;

  // True when the packed BCD value is the top count (tens=5, units=9).
  function automatic logic bcd_is_max(input bcd_t value);
    return (value[7:4] == TENS_MAX) && (value[3:0] == UNITS_MAX);
  endfunction

endpackage

// File: rtl/stopwatch_60s_if.sv
// -----------------------------------------------------------------------------
// stopwatch_60s_if
//   Key-pulse inputs and display/status outputs of the stopwatch.
//   - start_stop : one-cycle debounced pulse, toggles run/stop
//   - clear      : one-cycle debounced pulse, back to 00 and idle
//   - seg_data   : BCD elapsed seconds, [7:4] tens, [3:0] units
//   - running    : high while counting
//   - full       : high once 59 s has been reached
//   - led        : active-low LED bank, all on when full
//   master drives the keys and observes the display (board/bench side);
//   slave is the stopwatch itself.
// -----------------------------------------------------------------------------
interface stopwatch_60s_if;
  import stopwatch_60s_pkg::*;

  logic start_stop;
  logic clear;
  bcd_t seg_data;
  logic running;
  logic full;
  led_t led;

  modport master (
    output start_stop,
    output clear,
    input  seg_data,
    input  running,
    input  full,
    input  led
  );

  modport slave (
    input  start_stop,
    input  clear,
    output seg_data,
    output running,
    output full,
    output led
  );

endinterface

// File: rtl/stopwatch_60s_bcd_sec_counter.sv
// -----------------------------------------------------------------------------
// bcd_sec_counter
//   Two-digit BCD seconds counter, 00..59, saturating at 59.
//   - clk_in   : clock
//   - rst_n_in : asynchronous active-low reset
//   - inc      : advance by one second (ignored at 59)
//   - clr      : return to 00; wins over inc
//   - seg_data : packed BCD value, [7:4] tens, [3:0] units
//   - at_max   : high while the value is 59
// -----------------------------------------------------------------------------
module bcd_sec_counter
  import stopwatch_60s_pkg::*;
(
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic inc,
  input  logic clr,
  output bcd_t seg_data,
  output logic at_max
);

  logic [3:0] tens_q;
  logic [3:0] units_q;

  // Units roll into tens at 9; at 59 the value simply holds, so the
  // digits can never leave 0..9 / 0..5.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tens_q  <= 4'd0;
      units_q <= 4'd0;
    end else if (clr) begin
      tens_q  <= 4'd0;
      units_q <= 4'd0;
    end else if (inc && !at_max) begin
      if (units_q < UNITS_MAX) begin
        units_q <= units_q + 4'd1;
      end else begin
        units_q <= 4'd0;
        tens_q  <= tens_q + 4'd1;
      end
    end
  end

  assign seg_data = {tens_q, units_q};
  assign at_max   = bcd_is_max({tens_q, units_q});

endmodule

// File: rtl/stopwatch_60s.sv
// -----------------------------------------------------------------------------
// stopwatch_60s
//   0-59 s count-up stopwatch driven by debounced single-cycle key pulses.
//   - NUM_1S   : clk_in cycles per second
//   - clk_in   : the single clock of the block
//   - rst_n_in : asynchronous active-low reset
//   - sw       : key pulses in, BCD display / running / full / LED bank out
//   All outputs are registered: a key press or tick becomes visible the
//   cycle after the edge that sampled it.
// -----------------------------------------------------------------------------
module stopwatch_60s
  import stopwatch_60s_pkg::*;
#(
  parameter logic [23:0] NUM_1S = NUM_1S_DEFAULT
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  stopwatch_60s_if.slave  sw
);

  localparam logic [23:0] LAST_COUNT = NUM_1S - 24'd1;

  sw_state_t   state_q;
  sw_state_t   state_d;
  logic [23:0] prescaler_q;
  logic [23:0] prescaler_d;
  logic        tick;
  logic        at_max;
  bcd_t        seg_q;
  logic        running_q;
  logic        full_q;
  led_t        led_q;

  // One-second strobe; only meaningful while counting.
  assign tick = (state_q == RUN) && (prescaler_q == LAST_COUNT);

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. clear beats every other event. In RUN, reaching
  // the top count takes priority over a stop press on the same tick, so
  // a finished run always lands in FULL.
  always_comb begin
    state_d = state_q;
    if (sw.clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (sw.start_stop) state_d = RUN;
        RUN: begin
          if (tick && at_max) begin
            state_d = FULL;
          end else if (sw.start_stop) begin
            state_d = STOP;
          end
        end
        STOP: if (sw.start_stop) state_d = RUN;
        FULL: state_d = FULL;
        default: state_d = IDLE;
      endcase
    end
  end

  // Prescaler: advances only in RUN and holds in STOP so a resume picks
  // up the partial second. A fresh start from IDLE begins a full second.
  always_comb begin
    prescaler_d = prescaler_q;
    if (sw.clear) begin
      prescaler_d = 24'd0;
    end else if ((state_q == IDLE) && sw.start_stop) begin
      prescaler_d = 24'd0;
    end else if (state_q == RUN) begin
      prescaler_d = tick ? 24'd0 : prescaler_q + 24'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      prescaler_q <= 24'd0;
    end else begin
      prescaler_q <= prescaler_d;
    end
  end

  // Seconds digits; a tick on the same cycle as clear is discarded.
  bcd_sec_counter u_counter (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .inc      (tick && !sw.clear),
    .clr      (sw.clear),
    .seg_data (seg_q),
    .at_max   (at_max)
  );

  // Status outputs are decoded from the next state so they line up with
  // the state register and the BCD digits on the same cycle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      running_q <= 1'b0;
      full_q    <= 1'b0;
      led_q     <= LED_OFF;
    end else begin
      running_q <= (state_d == RUN);
      full_q    <= (state_d == FULL);
      led_q     <= (state_d == FULL) ? LED_ON : LED_OFF;
    end
  end

  assign sw.seg_data = seg_q;
  assign sw.running  = running_q;
  assign sw.full     = full_q;
  assign sw.led      = led_q;

endmodule

// File: doc/stopwatch_60s.md
Name: stopwatch_60s

Overview:
Count-up companion to the 60 s countdown timer: a 0–59 s stopwatch driven by debounced single-cycle key pulses.
- Holds elapsed seconds as two BCD digits (tens, units).
- BCD output feeds the existing two-digit seven-segment decoder unchanged.
- Saturates at 59 s and flags completion on the 14-bit active-low LED bank.

Parameters:
NUM_1S, 24'd12_000_000, clk_in cycles per second (12 MHz board clock); benches use 24'd20
LED_ON, 14'b0, LED pattern driven when full (active-low, all on)
LED_OFF, 14'b11_1111_1111_1111, LED pattern otherwise (all off)

Ports:
clk_in  input  1  system clock; the single clock for the whole block
rst_n_in  input  1  asynchronous, active-low reset
start_stop  input  1  one-cycle debounced pulse; toggles run/stop
clear  input  1  one-cycle debounced pulse; return to 00 and idle
seg_data  output  8  BCD elapsed seconds; [7:4] tens, [3:0] units
running  output  1  high while in RUN
full  output  1  high while in FULL (59 s reached)
led  output  14  LED_ON in FULL, else LED_OFF

Behaviour:
- Reset (asynchronous, rst_n_in low):
  - state=IDLE, seg_data=8'h00, prescaler=0.
  - running=0, full=0, led=LED_OFF.
  - Reset mid-count aborts immediately, with no tick pending.
- Prescaler (24-bit):
  - Counts 0..NUM_1S-1 and wraps, only while in RUN.
  - Holds its value in STOP, so a resume continues the partial second.
  - Forced to 0 on clear and when entering RUN from IDLE.
- tick: asserted when state==RUN and prescaler==NUM_1S-1.
- State machine (all outputs registered; change visible the cycle after the causing event):
  - IDLE: start_stop -> RUN.
  - RUN: start_stop -> STOP; clear -> IDLE; tick while seg_data==8'h59 -> FULL.
  - STOP: start_stop -> RUN; clear -> IDLE.
  - FULL: clear -> IDLE; start_stop ignored.
- BCD increment, on tick only, in RUN:
  - units<9: units+1.
  - units==9 and tens<5: units=0, tens+1.
  - seg_data==8'h59: value holds at 59 and state goes to FULL.
  - Digits never leave 0..9 (units) or 0..5 (tens).
- Simultaneous events:
  - clear together with start_stop: clear wins; IDLE, seg_data=00.
  - tick together with start_stop in RUN: increment applies and state becomes STOP. Example: 8'h09 -> 8'h10 and stopped.
  - tick together with clear: clear wins; seg_data=00.
- clear in IDLE: no visible change.
- Output decode:
  - running = (state==RUN).
  - full = (state==FULL).
  - led = full ? LED_ON : LED_OFF, registered.
- Latency: one second after the RUN entry, seg_data increments exactly NUM_1S cycles after the first RUN cycle.

Decomposition:
- Shared package:
  - NUM_1S default.
  - LED_ON / LED_OFF.
  - State encoding: IDLE=2'd0, RUN=2'd1, STOP=2'd2, FULL=2'd3.
  - BCD limits: units max 4'd9, tens max 4'd5.
- One sub-module: bcd_sec_counter.
  - Inputs: inc, clr.
  - Outputs: seg_data, at_max.
  - Implements the two-digit BCD increment and saturation.
- FSM and prescaler stay in the top.

Test Plan (NUM_1S=20):
- Reset then start_stop pulse -> running=1 next cycle; after 20 cycles seg_data=8'h01; after 200 cycles from start seg_data=8'h10.
- Run 5 s + 7 cycles, start_stop, idle 100 cycles, start_stop -> seg_data stays 8'h05 while stopped; becomes 8'h06 13 cycles after resume.
- Run to 59 and one more tick -> seg_data=8'h59, full=1, led=14'b0, running=0; further start_stop pulses leave state unchanged; clear -> 8'h00, led=all ones.
- At seg_data=8'h09, assert start_stop on the tick cycle -> seg_data=8'h10, running=0.
- Mid-run, assert clear and start_stop in the same cycle -> seg_data=8'h00, running=0, prescaler restarts from 0 on next start.
- Drop rst_n_in asynchronously at seg_data=8'h33 between clock edges -> outputs reach reset values before the next edge; release -> block idles at 00.
